// File: rtl/temp_disp_scan.sv
// Display stage for the LM07 temperature path: captures BCD digits and sign on
// the converter's done edge and scans them onto a 3-digit multiplexed 7-segment display.
module temp_disp_scan #(
  parameter int unsigned REFRESH_DIV      = 2500,
  parameter int unsigned DEAD_CYCLES      = 4,
  parameter int unsigned STALE_FRAMES     = 255,
  parameter bit          SEG_ACTIVE_LOW   = 1'b0,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic       SYSCLK,
  input  logic       RST,
  input  logic [3:0] BCD_MSB,
  input  logic [3:0] BCD_LSB,
  input  logic       SIGN,
  input  logic       DONE,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [2:0] DIGIT_EN,
  output logic       STALE,
  output logic       NEW_SAMPLE
);

  localparam int unsigned ON_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int unsigned STALE_W = $clog2(STALE_FRAMES + 1);

  localparam logic [ON_W-1:0]    ON_LAST    = ON_W'(REFRESH_DIV - 1);
  localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(STALE_FRAMES);
  localparam logic [STALE_W-1:0] STALE_PRE  = STALE_W'(STALE_FRAMES - 1);

  localparam logic [6:0] SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic [2:0] DIG_OFF   = {3{DIGIT_ACTIVE_LOW}};
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_E     = 7'b1111001;

  localparam logic [1:0] IDX_ONES = 2'd0;
  localparam logic [1:0] IDX_TENS = 2'd1;
  localparam logic [1:0] IDX_SIGN = 2'd2;

  typedef enum logic {
    S_DEAD = 1'b0,
    S_ON   = 1'b1
  } scan_state_t;

  scan_state_t         state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic [ON_W-1:0]     on_cnt_q, on_cnt_d;
  logic [6:0]          seg_q, seg_d;
  logic [2:0]          dig_q, dig_d;
  logic                frame_end;

  logic                done_q;
  logic                capture;
  logic [3:0]          hold_msb, hold_lsb;
  logic                hold_sign;
  logic                err_q;
  logic                stale_q;
  logic [STALE_W-1:0]  stale_cnt_q;
  logic                new_sample_q;

  function automatic logic [6:0] seg_font(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Priority: stale dashes, then error 'E E', then the captured reading
  // with leading-zero blanking and no sign on a zero reading.
  function automatic logic [6:0] digit_seg(input logic [1:0] idx,
                                           input logic       stale,
                                           input logic       err,
                                           input logic [3:0] msb,
                                           input logic [3:0] lsb,
                                           input logic       sgn);
    logic [6:0] s;
    s = SEG_BLANK;
    if (stale) begin
      s = SEG_MINUS;
    end else if (err) begin
      s = (idx == IDX_SIGN) ? SEG_BLANK : SEG_E;
    end else begin
      case (idx)
        IDX_ONES: s = seg_font(lsb);
        IDX_TENS: s = (msb == 4'd0) ? SEG_BLANK : seg_font(msb);
        IDX_SIGN: s = (sgn && ({msb, lsb} != 8'd0)) ? SEG_MINUS : SEG_BLANK;
        default:  s = SEG_BLANK;
      endcase
    end
    return s;
  endfunction

  assign capture = DONE & ~done_q;

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_q    <= S_DEAD;
      idx_q      <= IDX_ONES;
      dead_cnt_q <= '0;
      on_cnt_q   <= '0;
      seg_q      <= SEG_OFF;
      dig_q      <= DIG_OFF;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dead_cnt_q <= dead_cnt_d;
      on_cnt_q   <= on_cnt_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  // Segment pattern is latched only at DEAD->ON so a lit digit never changes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dead_cnt_d = dead_cnt_q;
    on_cnt_d   = on_cnt_q;
    seg_d      = seg_q;
    dig_d      = dig_q;
    frame_end  = 1'b0;
    case (state_q)
      S_DEAD: begin
        if (dead_cnt_q == DEAD_LAST) begin
          state_d    = S_ON;
          dead_cnt_d = '0;
          on_cnt_d   = '0;
          dig_d      = DIG_OFF ^ (3'b001 << idx_q);
          seg_d      = SEG_OFF ^ digit_seg(idx_q, stale_q, err_q,
                                           hold_msb, hold_lsb, hold_sign);
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      S_ON: begin
        if (on_cnt_q == ON_LAST) begin
          state_d    = S_DEAD;
          on_cnt_d   = '0;
          dead_cnt_d = '0;
          dig_d      = DIG_OFF;
          seg_d      = SEG_OFF;
          frame_end  = (idx_q == IDX_SIGN);
          idx_d      = (idx_q == IDX_SIGN) ? IDX_ONES : idx_q + 1'b1;
        end else begin
          on_cnt_d = on_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_DEAD;
      end
    endcase
  end

  // Capture and staleness; a capture on a frame-end edge takes precedence.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      done_q       <= 1'b0;
      hold_msb     <= 4'd0;
      hold_lsb     <= 4'd0;
      hold_sign    <= 1'b0;
      err_q        <= 1'b0;
      stale_q      <= 1'b1;
      stale_cnt_q  <= '0;
      new_sample_q <= 1'b0;
    end else begin
      done_q       <= DONE;
      new_sample_q <= capture;
      if (capture) begin
        hold_msb    <= BCD_MSB;
        hold_lsb    <= BCD_LSB;
        hold_sign   <= SIGN;
        err_q       <= (BCD_MSB > 4'd9) || (BCD_LSB > 4'd9);
        stale_q     <= 1'b0;
        stale_cnt_q <= '0;
      end else if (frame_end && (stale_cnt_q != STALE_MAX)) begin
        stale_cnt_q <= stale_cnt_q + 1'b1;
        if (stale_cnt_q == STALE_PRE) begin
          stale_q <= 1'b1;
        end
      end
    end
  end

  assign SEG        = seg_q;
  assign DIGIT_EN   = dig_q;
  assign DP         = SEG_ACTIVE_LOW;
  assign STALE      = stale_q;
  assign NEW_SAMPLE = new_sample_q;

endmodule

// File: tb/tb_temp_disp_scan.sv
// Bench for temp_disp_scan: directed and randomized DONE/BCD/RST stimulus
// compared every cycle against a frame-position reference model.
module tb_temp_disp_scan;

  localparam int R     = 4;
  localparam int D     = 2;
  localparam int SF    = 3;
  localparam int SLOT  = R + D;
  localparam int FRAME = 3 * SLOT;

  logic       SYSCLK = 1'b0;
  logic       RST    = 1'b1;
  logic [3:0] BCD_MSB = 4'd0;
  logic [3:0] BCD_LSB = 4'd0;
  logic       SIGN = 1'b0;
  logic       DONE = 1'b0;
  logic [6:0] SEG;
  logic       DP;
  logic [2:0] DIGIT_EN;
  logic       STALE;
  logic       NEW_SAMPLE;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int         n;
  int         m_cnt;
  logic [3:0] m_msb, m_lsb;
  logic       m_sign, m_err, m_stale, m_prev, m_new;
  logic [6:0] m_seg;
  logic [6:0] font [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  localparam logic [6:0] MINUS = 7'b1000000;
  localparam logic [6:0] E_SEG = 7'b1111001;

  temp_disp_scan #(
    .REFRESH_DIV(R), .DEAD_CYCLES(D), .STALE_FRAMES(SF),
    .SEG_ACTIVE_LOW(1'b0), .DIGIT_ACTIVE_LOW(1'b0)
  ) dut (
    .SYSCLK(SYSCLK), .RST(RST), .BCD_MSB(BCD_MSB), .BCD_LSB(BCD_LSB),
    .SIGN(SIGN), .DONE(DONE), .SEG(SEG), .DP(DP), .DIGIT_EN(DIGIT_EN),
    .STALE(STALE), .NEW_SAMPLE(NEW_SAMPLE)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
  endtask

  function automatic logic [6:0] ref_digit(input int slot);
    if (m_stale) return MINUS;
    if (m_err) return (slot == 2) ? 7'b0 : E_SEG;
    case (slot)
      0:       return font[m_lsb];
      1:       return (m_msb == 4'd0) ? 7'b0 : font[m_msb];
      default: return (m_sign && ({m_msb, m_lsb} != 8'd0)) ? MINUS : 7'b0;
    endcase
  endfunction

  function automatic logic [3:0] pick_digit();
    int r;
    r = $urandom_range(0, 15);
    if (r < 4) return 4'd0;
    if (r < 14) return 4'($urandom_range(0, 9));
    return 4'($urandom_range(10, 15));
  endfunction

  // One clock: advance the model with the inputs the DUT just sampled, then compare.
  task automatic tick();
    int   pos, slot;
    logic cap, lit;
    logic [2:0] exp_en;
    @(posedge SYSCLK);
    if (RST) begin
      n = 0; m_cnt = 0; m_msb = 4'd0; m_lsb = 4'd0; m_sign = 1'b0; m_err = 1'b0;
      m_stale = 1'b1; m_prev = 1'b0; m_new = 1'b0; m_seg = 7'b0;
    end else begin
      n++;
      pos  = (n - 1) % SLOT;
      slot = ((n - 1) / SLOT) % 3;
      if (pos == D - 1) m_seg = ref_digit(slot);
      cap    = DONE && !m_prev;
      m_prev = DONE;
      m_new  = cap;
      if (cap) begin
        m_msb = BCD_MSB; m_lsb = BCD_LSB; m_sign = SIGN;
        m_err = (BCD_MSB > 4'd9) || (BCD_LSB > 4'd9);
        m_stale = 1'b0; m_cnt = 0;
      end else if (n % FRAME == 0) begin
        if (m_cnt < SF) m_cnt++;
        if (m_cnt == SF) m_stale = 1'b1;
      end
    end
    #1;
    lit = 1'b0; slot = 0;
    if (n > 0) begin
      pos  = (n - 1) % SLOT;
      slot = ((n - 1) / SLOT) % 3;
      lit  = (pos >= D - 1) && (pos < D - 1 + R);
    end
    exp_en = lit ? 3'(1 << slot) : 3'b000;
    check("digit_en", 32'(DIGIT_EN), 32'(exp_en));
    if (lit) check("seg", 32'(SEG), 32'(m_seg));
    if (n == 0) check("seg_reset", 32'(SEG), 32'd0);
    check("stale", 32'(STALE), 32'(m_stale));
    check("new_sample", 32'(NEW_SAMPLE), 32'(m_new));
    check("dp", 32'(DP), 32'd0);
  endtask

  task automatic capture(input logic [3:0] msb, input logic [3:0] lsb, input logic sgn);
    DONE = 1'b0;
    tick();
    BCD_MSB = msb; BCD_LSB = lsb; SIGN = sgn; DONE = 1'b1;
    tick();
  endtask

  initial begin
    logic found;
    RST = 1'b1; DONE = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    repeat (60) tick();

    capture(4'd2, 4'd5, 1'b0);  repeat (40) tick();
    capture(4'd0, 4'd7, 1'b1);  repeat (40) tick();
    capture(4'd0, 4'd0, 1'b1);  repeat (40) tick();
    capture(4'hA, 4'd3, 1'b0);  repeat (40) tick();
    capture(4'd1, 4'd9, 1'b1);  repeat (40) tick();
    capture(4'd3, 4'd1, 1'b0);  repeat (60) tick();

    // new capture landing exactly on the edge that would assert STALE
    capture(4'd8, 4'd6, 1'b1);
    DONE = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_cnt == SF - 1 && (n + 1) % FRAME == 0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("align_frame_end", 32'(found), 32'd1);
    BCD_MSB = 4'd4; BCD_LSB = 4'd2; SIGN = 1'b0; DONE = 1'b1;
    tick();
    repeat (30) tick();

    // reset in the middle of a lit period, with DONE high at release
    for (int i = 0; i < 40 && ((n % SLOT) != 3); i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0; BCD_MSB = 4'd1; BCD_LSB = 4'd4; SIGN = 1'b1;
    repeat (40) tick();

    for (int c = 0; c < 3000; c++) begin
      RST = (RST && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 29) == 0) DONE = ~DONE;
      BCD_MSB = pick_digit();
      BCD_LSB = pick_digit();
      SIGN    = 1'($urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/temp_disp_scan.md
Name: temp_disp_scan

Overview:
Downstream display stage for the LM07 temperature path. Captures the two BCD digits and the sign produced by the binary-to-BCD stage when its done flag rises. Drives a 3-digit multiplexed 7-segment display (sign, tens, ones) with dead-time between digits, leading-zero blanking, invalid-digit indication and a stale-data timeout.

Parameters:
REFRESH_DIV, 2500, SYSCLK cycles each digit is lit (>=1)
DEAD_CYCLES, 4, SYSCLK cycles with all digits off between digits (>=1)
STALE_FRAMES, 255, full scan frames without a new capture before STALE asserts (>=1)
SEG_ACTIVE_LOW, 0, 1 = SEG/DP inverted at the pins
DIGIT_ACTIVE_LOW, 0, 1 = DIGIT_EN inverted at the pins

Ports:
SYSCLK  in  1  system clock, all logic on posedge
RST  in  1  synchronous reset, active-high
BCD_MSB  in  4  tens digit from BCD converter
BCD_LSB  in  4  ones digit from BCD converter
SIGN  in  1  sensor sign bit, 1 = negative
DONE  in  1  converter done level; a rising edge marks valid BCD_MSB/BCD_LSB/SIGN
SEG  out  7  segments {g,f,e,d,c,b,a}
DP  out  1  decimal point, always inactive
DIGIT_EN  out  3  one-hot digit select: [0] ones, [1] tens, [2] sign
STALE  out  1  1 = no capture within STALE_FRAMES frames, or none since reset
NEW_SAMPLE  out  1  one-cycle pulse on the cycle after a capture

Behaviour:
- Reset (RST high at posedge): scan state=DEAD, index=0, dead/on counters=0, DONE_q=0, hold regs=0, err=0, STALE=1, stale count=0, NEW_SAMPLE=0, DIGIT_EN all inactive, SEG blank (inactive), DP inactive. Reset mid-scan or mid-capture aborts immediately with the same values.
- Capture: on a posedge where DONE=1 and DONE_q=0, load hold_msb/hold_lsb/hold_sign, set err=1 if either digit >9 (else 0), clear STALE, clear stale count. NEW_SAMPLE=1 on the next cycle only. DONE held high causes no further capture. DONE high at reset release captures on the first edge.
- Scan FSM, two states:
  - DEAD: DIGIT_EN all inactive for DEAD_CYCLES cycles. On the last cycle, go to ON. In the same edge, register DIGIT_EN one-hot for the current index and register SEG for that digit.
  - ON: hold DIGIT_EN and SEG for exactly REFRESH_DIV cycles. Then go to DEAD with DIGIT_EN inactive; index <= (index==2)?0:index+1.
  - First DIGIT_EN (index 0) goes active DEAD_CYCLES edges after the first edge with RST low.
- Frame = 3*(REFRESH_DIV+DEAD_CYCLES) cycles. The stale counter increments when index 2 leaves ON and saturates at STALE_FRAMES. On reaching STALE_FRAMES, STALE=1. A capture on the same edge wins: STALE=0, count=0.
- SEG is sampled only at DEAD->ON. A capture during ON never changes a lit digit mid-period.
- Digit content, priority order:
  1. STALE=1: all three digits '-'.
  2. err=1: ones 'E', tens 'E', sign blank.
  3. Otherwise:
     - ones: hold_lsb.
     - tens: blank if hold_msb==0, else hold_msb.
     - sign: '-' if hold_sign=1 and {msb,lsb}!=0, else blank.
- Codes {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - '-'=1000000, 'E'=1111001, blank=0000000
- Output polarity: apply SEG_ACTIVE_LOW / DIGIT_ACTIVE_LOW inversion at output registers. "Inactive" above means the post-inversion off level.

Test Plan:
(All use REFRESH_DIV=4, DEAD_CYCLES=2, STALE_FRAMES=3, active-high; frame=18 cycles.)
- Reset 3 cycles, DONE=0 -> DIGIT_EN=000 for 2 cycles, then 001 for 4 cycles; STALE=1; SEG=1000000 on each of 001/010/100; DIGIT_EN never two-hot, 2 zero cycles between digits.
- DONE 0->1 with MSB=2, LSB=5, SIGN=0 -> NEW_SAMPLE one pulse, STALE=0; next frame ones=1101101, tens=1011011, sign=0000000.
- MSB=0, LSB=7, SIGN=1 -> ones=0000111, tens=0000000, sign=1000000; then MSB=0, LSB=0, SIGN=1 -> ones=0111111, tens blank, sign blank.
- MSB=4'hA, LSB=3 -> ones=1111001, tens=1111001, sign blank; next valid capture restores digits.
- Capture then DONE held high 54 cycles -> no second NEW_SAMPLE; STALE=1 after third frame end, all digits '-'. A DONE edge on that same edge keeps STALE=0.
- DONE edge mid-ON of ones -> SEG constant for the whole ON period; new value shown next lit period. RST asserted mid-ON -> next cycle DIGIT_EN=000, STALE=1, scan restarts at index 0.
